// File: rtl/ant_datapath_pkg.sv
// ant_datapath_pkg: shared widths, instruction field positions, opcodes and
// datapath state encodings for the ant datapath and its state RAM.
package ant_datapath_pkg;

    localparam int OPCODE_WIDTH      = 4;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int RESULT_WIDTH      = 16;
    localparam int MEM_ADDR_WIDTH    = 8;
    localparam int X_COORD_WIDTH     = 8;
    localparam int Y_COORD_WIDTH     = 7;
    localparam int COLOUR_WIDTH      = 3;
    localparam int SCREEN_W          = 160;
    localparam int SCREEN_H          = 120;
    localparam int BLOCK_W           = 4;
    localparam int BLOCK_H           = 4;

    // Instruction field positions (LSB of each field)
    localparam int FLD_OP_LSB    = 0;
    localparam int FLD_ADDR_LSB  = 4;
    localparam int FLD_WDATA_LSB = 12;
    localparam int FLD_X_LSB     = 4;
    localparam int FLD_Y_LSB     = 12;
    localparam int FLD_COL_LSB   = 19;
    localparam int FLD_PLOT_BIT  = 22;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_NOP      = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_MEMREAD  = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_MEMWRITE = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW     = 4'd3;

    typedef enum logic [2:0] {
        ANTDP_IDLE,
        ANTDP_READ_ADDR,
        ANTDP_READ_DATA,
        ANTDP_WRITE,
        ANTDP_DRAW,
        ANTDP_DONE
    } antdp_state_e;

    function automatic logic [OPCODE_WIDTH-1:0] get_op(input logic [INSTRUCTION_WIDTH-1:0] ins);
        return ins[FLD_OP_LSB +: OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/ant_datapath_if.sv
// ant_datapath_if: command handshake (start/instruction/finished/result),
// VGA adapter pixel port and sticky illegal-op flag of the ant datapath.
//   master: initiator side (drives start/instruction)
//   slave : datapath side (drives everything else)
interface ant_datapath_if;
    import ant_datapath_pkg::*;

    logic                         start;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         finished;
    logic [RESULT_WIDTH-1:0]      result;
    logic [X_COORD_WIDTH-1:0]     vga_x;
    logic [Y_COORD_WIDTH-1:0]     vga_y;
    logic [COLOUR_WIDTH-1:0]      vga_colour;
    logic                         vga_plot;
    logic                         illegal_op;

    modport master (
        output start, instruction,
        input  finished, result, vga_x, vga_y, vga_colour, vga_plot, illegal_op
    );

    modport slave (
        input  start, instruction,
        output finished, result, vga_x, vga_y, vga_colour, vga_plot, illegal_op
    );
endinterface

// File: rtl/ant_state_ram.sv
// ant_state_ram: single-port synchronous RAM, 1-cycle read latency, no reset.
//   clock   : system clock
//   we_i    : write enable
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data of addr_i (read-before-write)
module ant_state_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we_i) mem[addr_i] <= wdata_i;
        rdata_o <= mem[addr_i];
    end
endmodule

// File: rtl/ant_datapath.sv
// ant_datapath: responder for the start/instruction/finished/result command
// interface. Executes NOP, MEMREAD, MEMWRITE (internal state RAM) and DRAW
// (clipped BLOCK_W x BLOCK_H pixel fill on the VGA port).
//   clock, reset : system clock, synchronous active-high reset
//   dp (slave)   : command handshake, VGA pixel port, sticky illegal_op
module ant_datapath
    import ant_datapath_pkg::*;
#(
    parameter int BLOCK_W  = ant_datapath_pkg::BLOCK_W,
    parameter int BLOCK_H  = ant_datapath_pkg::BLOCK_H,
    parameter int SCREEN_W = ant_datapath_pkg::SCREEN_W,
    parameter int SCREEN_H = ant_datapath_pkg::SCREEN_H
) (
    input  logic           clock,
    input  logic           reset,
    ant_datapath_if.slave  dp
);
    localparam int CXW  = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int CYW  = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam int CNTW = $clog2(BLOCK_W * BLOCK_H + 1);

    antdp_state_e                 state_q, state_d;
    logic                         start_q;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic                         finished_q, finished_d;
    logic [RESULT_WIDTH-1:0]      result_q, result_d;
    logic [X_COORD_WIDTH-1:0]     vga_x_q, vga_x_d;
    logic [Y_COORD_WIDTH-1:0]     vga_y_q, vga_y_d;
    logic [COLOUR_WIDTH-1:0]      vga_col_q, vga_col_d;
    logic                         vga_plot_q, vga_plot_d;
    logic                         illegal_q, illegal_d;
    logic [CXW-1:0]               cx_q, cx_d;
    logic [CYW-1:0]               cy_q, cy_d;
    logic [CNTW-1:0]              npix_q, npix_d;

    logic                         ram_we;
    logic [RESULT_WIDTH-1:0]      ram_rdata;

    // Latched instruction fields
    logic [OPCODE_WIDTH-1:0]      op;
    logic [MEM_ADDR_WIDTH-1:0]    addr;
    logic [RESULT_WIDTH-1:0]      wdata;
    logic [X_COORD_WIDTH-1:0]     dx;
    logic [Y_COORD_WIDTH-1:0]     dy;
    logic [COLOUR_WIDTH-1:0]      dcol;
    logic                         dplot;

    assign op    = get_op(instr_q);
    assign addr  = instr_q[FLD_ADDR_LSB  +: MEM_ADDR_WIDTH];
    assign wdata = instr_q[FLD_WDATA_LSB +: RESULT_WIDTH];
    assign dx    = instr_q[FLD_X_LSB     +: X_COORD_WIDTH];
    assign dy    = instr_q[FLD_Y_LSB     +: Y_COORD_WIDTH];
    assign dcol  = instr_q[FLD_COL_LSB   +: COLOUR_WIDTH];
    assign dplot = instr_q[FLD_PLOT_BIT];

    // Pixel coordinates one bit wider than the screen fields so that blocks
    // near the right/bottom edge clip instead of wrapping to column/row 0.
    logic [X_COORD_WIDTH:0] sx;
    logic [Y_COORD_WIDTH:0] sy;
    logic                   in_bounds;

    assign sx        = {1'b0, dx} + (X_COORD_WIDTH+1)'(cx_q);
    assign sy        = {1'b0, dy} + (Y_COORD_WIDTH+1)'(cy_q);
    assign in_bounds = (sx < (X_COORD_WIDTH+1)'(SCREEN_W)) && (sy < (Y_COORD_WIDTH+1)'(SCREEN_H));

    // A write still pending when reset hits is dropped.
    ant_state_ram #(.AW(MEM_ADDR_WIDTH), .DW(RESULT_WIDTH)) u_ram (
        .clock   (clock),
        .we_i    (ram_we & ~reset),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        finished_d = finished_q;
        result_d   = result_q;
        vga_x_d    = vga_x_q;
        vga_y_d    = vga_y_q;
        vga_col_d  = vga_col_q;
        vga_plot_d = 1'b0;
        illegal_d  = illegal_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        npix_d     = npix_q;
        ram_we     = 1'b0;

        unique case (state_q)
            ANTDP_IDLE: begin
                // Only a rising edge of start launches a command.
                if (dp.start && !start_q) begin
                    instr_d    = dp.instruction;
                    finished_d = 1'b0;
                    cx_d       = '0;
                    cy_d       = '0;
                    npix_d     = '0;
                    case (get_op(dp.instruction))
                        OPCODE_MEMREAD:  state_d = ANTDP_READ_ADDR;
                        OPCODE_MEMWRITE: state_d = ANTDP_WRITE;
                        OPCODE_DRAW:     state_d = dp.instruction[FLD_PLOT_BIT] ? ANTDP_DRAW : ANTDP_DONE;
                        default:         state_d = ANTDP_DONE;
                    endcase
                end
            end
            // RAM samples addr on this edge; data is valid one cycle later.
            ANTDP_READ_ADDR: state_d = ANTDP_READ_DATA;
            ANTDP_READ_DATA: begin
                result_d   = ram_rdata;
                finished_d = 1'b1;
                state_d    = ANTDP_IDLE;
            end
            ANTDP_WRITE: begin
                ram_we     = 1'b1;
                result_d   = wdata;
                finished_d = 1'b1;
                state_d    = ANTDP_IDLE;
            end
            ANTDP_DRAW: begin
                vga_x_d    = sx[X_COORD_WIDTH-1:0];
                vga_y_d    = sy[Y_COORD_WIDTH-1:0];
                vga_col_d  = dcol;
                vga_plot_d = in_bounds;
                npix_d     = npix_q + CNTW'(in_bounds);
                if (cx_q == CXW'(BLOCK_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == CYW'(BLOCK_H - 1)) state_d = ANTDP_DONE;
                    else                           cy_d    = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            ANTDP_DONE: begin
                finished_d = 1'b1;
                state_d    = ANTDP_IDLE;
                case (op)
                    OPCODE_NOP:  result_d = '0;
                    OPCODE_DRAW: result_d = dplot ? RESULT_WIDTH'(npix_q) : '0;
                    default: begin
                        result_d  = '1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: state_d = ANTDP_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ANTDP_IDLE;
            start_q    <= 1'b1;  // a start held across reset must fall first
            instr_q    <= '0;
            finished_q <= 1'b1;
            result_q   <= '0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            vga_col_q  <= '0;
            vga_plot_q <= 1'b0;
            illegal_q  <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            npix_q     <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= dp.start;
            instr_q    <= instr_d;
            finished_q <= finished_d;
            result_q   <= result_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            vga_col_q  <= vga_col_d;
            vga_plot_q <= vga_plot_d;
            illegal_q  <= illegal_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            npix_q     <= npix_d;
        end
    end

    assign dp.finished   = finished_q;
    assign dp.result     = result_q;
    assign dp.vga_x      = vga_x_q;
    assign dp.vga_y      = vga_y_q;
    assign dp.vga_colour = vga_col_q;
    assign dp.vga_plot   = vga_plot_q;
    assign dp.illegal_op = illegal_q;
endmodule

// File: tb/tb_ant_datapath.sv
// tb_ant_datapath: directed self-checking bench for ant_datapath.
module tb_ant_datapath;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ant_datapath_if bus ();

    ant_datapath dut (
        .clock (clock),
        .reset (reset),
        .dp    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Per-command observations collected by send()
    int lat, fin_e, pix_n, pix_sx, pix_sy, minx, maxx, miny, maxy, colbad;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk_draw(input int x, input int y, input int c, input bit p);
        logic [31:0] w;
        w = 32'd3;
        w[11:4]  = x[7:0];
        w[18:12] = y[6:0];
        w[21:19] = c[2:0];
        w[22]    = p;
        return w;
    endfunction

    function automatic logic [31:0] mk_mem(input int op, input int a, input int d);
        logic [31:0] w;
        w = '0;
        w[3:0]   = op[3:0];
        w[11:4]  = a[7:0];
        w[27:12] = d[15:0];
        return w;
    endfunction

    // Issue one command with start held for two edges, then run until
    // finished rises (bounded); records latency and plotted pixels.
    task automatic send(input logic [31:0] ins, input logic [2:0] col);
        pix_n = 0; pix_sx = 0; pix_sy = 0; colbad = 0;
        minx = 999; maxx = -1; miny = 999; maxy = -1;
        lat = -1;
        bus.instruction = ins;
        bus.start = 1'b1;
        tick;  // edge E
        fin_e = int'(bus.finished);
        for (int k = 1; k <= 100; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            if (bus.vga_plot) begin
                pix_n++;
                pix_sx += int'(bus.vga_x);
                pix_sy += int'(bus.vga_y);
                if (int'(bus.vga_x) < minx) minx = int'(bus.vga_x);
                if (int'(bus.vga_x) > maxx) maxx = int'(bus.vga_x);
                if (int'(bus.vga_y) < miny) miny = int'(bus.vga_y);
                if (int'(bus.vga_y) > maxy) maxy = int'(bus.vga_y);
                if (bus.vga_colour !== col) colbad++;
            end
            if (bus.finished) begin
                lat = k;
                break;
            end
        end
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.instruction = mk_mem(2, 7, 99);
        tick; tick;
        checks++;
        if (bus.finished !== 1'b1 || bus.result !== 16'd0 || bus.vga_plot !== 1'b0 ||
            bus.illegal_op !== 1'b0 || bus.vga_x !== 8'd0 || bus.vga_y !== 7'd0 || bus.vga_colour !== 3'd0) begin
            errors++;
            $display("FAIL reset_values fin=%b res=%h plot=%b ill=%b x=%0d y=%0d c=%0d expected 1/0/0/0/0/0/0",
                     bus.finished, bus.result, bus.vga_plot, bus.illegal_op, bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        reset = 1'b0;
        tick; tick; tick;
        checks++;
        if (bus.finished !== 1'b1 || bus.result !== 16'd0) begin
            errors++;
            $display("FAIL start_held_over_reset fin=%b res=%h expected fin=1 res=0", bus.finished, bus.result);
        end
        bus.start = 1'b0;
        tick;
    endtask

    task automatic test_memory;
        send(mk_mem(2, 5, 37), 3'd0);
        checks++;
        if (fin_e !== 0 || lat !== 1 || bus.result !== 16'd37) begin
            errors++;
            $display("FAIL memwrite fin_at_E=%0d lat=%0d res=%0d expected 0/1/37", fin_e, lat, bus.result);
        end
        send(mk_mem(2, 6, 16'h1234), 3'd0);
        checks++;
        if (lat !== 1 || bus.result !== 16'h1234) begin
            errors++;
            $display("FAIL memwrite2 lat=%0d res=%h expected 1/1234", lat, bus.result);
        end
        send(mk_mem(1, 5, 0), 3'd0);
        checks++;
        if (fin_e !== 0 || lat !== 2 || bus.result !== 16'd37 || pix_n !== 0) begin
            errors++;
            $display("FAIL memread5 fin_at_E=%0d lat=%0d res=%0d pix=%0d expected 0/2/37/0", fin_e, lat, bus.result, pix_n);
        end
        send(mk_mem(1, 6, 0), 3'd0);
        checks++;
        if (lat !== 2 || bus.result !== 16'h1234) begin
            errors++;
            $display("FAIL memread6 lat=%0d res=%h expected 2/1234", lat, bus.result);
        end
    endtask

    task automatic test_draw;
        send(mk_draw(10, 20, 3, 1'b1), 3'd3);
        checks++;
        if (lat !== 17 || pix_n !== 16 || colbad !== 0 || bus.result !== 16'd16) begin
            errors++;
            $display("FAIL draw_basic lat=%0d pix=%0d colbad=%0d res=%0d expected 17/16/0/16", lat, pix_n, colbad, bus.result);
        end
        checks++;
        if (minx !== 10 || maxx !== 13 || miny !== 20 || maxy !== 23 || pix_sx !== 184 || pix_sy !== 344) begin
            errors++;
            $display("FAIL draw_coords x=%0d..%0d y=%0d..%0d sx=%0d sy=%0d expected 10..13 20..23 184 344",
                     minx, maxx, miny, maxy, pix_sx, pix_sy);
        end
    endtask

    task automatic test_clip;
        send(mk_draw(158, 118, 5, 1'b1), 3'd5);
        checks++;
        if (lat !== 17 || pix_n !== 4 || bus.result !== 16'd4 || colbad !== 0) begin
            errors++;
            $display("FAIL draw_clip lat=%0d pix=%0d res=%0d colbad=%0d expected 17/4/4/0", lat, pix_n, bus.result, colbad);
        end
        checks++;
        if (minx !== 158 || maxx !== 159 || miny !== 118 || maxy !== 119) begin
            errors++;
            $display("FAIL clip_coords x=%0d..%0d y=%0d..%0d expected 158..159 118..119", minx, maxx, miny, maxy);
        end
    endtask

    task automatic test_plot0;
        send(mk_draw(10, 20, 3, 1'b0), 3'd3);
        checks++;
        if (lat !== 1 || pix_n !== 0 || bus.result !== 16'd0) begin
            errors++;
            $display("FAIL draw_noplot lat=%0d pix=%0d res=%0d expected 1/0/0", lat, pix_n, bus.result);
        end
    endtask

    task automatic test_illegal;
        checks++;
        if (bus.illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pre ill=%b expected 0", bus.illegal_op);
        end
        send(mk_mem(9, 0, 0), 3'd0);
        checks++;
        if (lat !== 1 || bus.result !== 16'hFFFF || bus.illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op lat=%0d res=%h ill=%b expected 1/ffff/1", lat, bus.result, bus.illegal_op);
        end
    endtask

    task automatic test_nop;
        send(32'd0, 3'd0);
        checks++;
        if (lat !== 1 || bus.result !== 16'd0 || bus.illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL nop lat=%0d res=%0d ill=%b expected 1/0/1 (sticky)", lat, bus.result, bus.illegal_op);
        end
    endtask

    task automatic test_busy_ignore;
        int n = 0;
        int l = -1;
        bus.instruction = mk_draw(40, 50, 6, 1'b1);
        bus.start = 1'b1;
        tick;  // E
        for (int k = 1; k <= 100; k++) begin
            tick;
            if (k == 1) bus.start = 1'b0;
            if (k == 5) begin
                bus.start = 1'b1;
                bus.instruction = mk_mem(2, 5, 111);
            end
            if (k == 7) bus.start = 1'b0;
            if (bus.vga_plot) n++;
            if (bus.finished) begin
                l = k;
                break;
            end
        end
        checks++;
        if (l !== 17 || n !== 16 || bus.result !== 16'd16) begin
            errors++;
            $display("FAIL busy_ignore lat=%0d pix=%0d res=%0d expected 17/16/16", l, n, bus.result);
        end
        tick; tick; tick;
        checks++;
        if (bus.finished !== 1'b1 || bus.result !== 16'd16) begin
            errors++;
            $display("FAIL busy_no_late fin=%b res=%0d expected 1/16", bus.finished, bus.result);
        end
        send(mk_mem(1, 5, 0), 3'd0);
        checks++;
        if (bus.result !== 16'd37) begin
            errors++;
            $display("FAIL busy_no_write res=%0d expected 37", bus.result);
        end
    endtask

    task automatic test_reset_mid_draw;
        bus.instruction = mk_draw(10, 20, 2, 1'b1);
        bus.start = 1'b1;
        tick; tick; tick; tick;
        checks++;
        if (bus.finished !== 1'b0 || bus.vga_plot !== 1'b1) begin
            errors++;
            $display("FAIL mid_draw_busy fin=%b plot=%b expected 0/1", bus.finished, bus.vga_plot);
        end
        reset = 1'b1;
        tick;
        checks++;
        if (bus.finished !== 1'b1 || bus.vga_plot !== 1'b0 || bus.illegal_op !== 1'b0 || bus.result !== 16'd0) begin
            errors++;
            $display("FAIL mid_draw_reset fin=%b plot=%b ill=%b res=%0d expected 1/0/0/0",
                     bus.finished, bus.vga_plot, bus.illegal_op, bus.result);
        end
        reset = 1'b0;
        tick; tick; tick;
        checks++;
        if (bus.finished !== 1'b1 || bus.vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle fin=%b plot=%b expected 1/0", bus.finished, bus.vga_plot);
        end
        bus.start = 1'b0;
        tick;
        send(mk_mem(1, 5, 0), 3'd0);
        checks++;
        if (fin_e !== 0 || lat !== 2 || bus.result !== 16'd37) begin
            errors++;
            $display("FAIL post_reset_read fin_at_E=%0d lat=%0d res=%0d expected 0/2/37", fin_e, lat, bus.result);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.instruction = '0;
        test_reset;
        test_memory;
        test_draw;
        test_clip;
        test_plot0;
        test_illegal;
        test_nop;
        test_busy_ignore;
        test_reset_mid_draw;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
